// File: rtl/rl_pkg.sv
// rl_pkg: shared definitions for red_light_monitor.
// Holds the lane encoding, the event record that travels through the event FIFO,
// and the helper that maps (approach, lane) to a flat source index.
// The event record uses fixed container widths. It supports up to 256 approaches
// and timestamps up to 32 bits. The top module zero-extends its fields into the record.
package rl_pkg;

    localparam logic LANE_THRU = 1'b0;
    localparam logic LANE_LEFT = 1'b1;

    localparam int EVT_DIR_W = 8;
    localparam int EVT_TS_W  = 32;

    typedef struct packed {
        logic [EVT_DIR_W-1:0] dir;
        logic                 left;
        logic [EVT_TS_W-1:0]  ts;
    } rl_evt_t;

    // Source index: through lane of approach d is 2*d, left lane is 2*d+1.
    function automatic int unsigned src_idx(input int unsigned dir, input logic lane);
        return 2 * dir + 32'(lane);
    endfunction

endpackage

// File: rtl/rl_event_fifo.sv
// rl_event_fifo: first-word-fall-through FIFO for violation event records.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, din_i    write strobe and record (ignored when full)
//   pop_i            read strobe (ignored when empty)
//   dout_o           head record, forced to zero while empty
//   empty_o, full_o  occupancy flags
module rl_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit to distinguish full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/red_light_monitor.sv
// red_light_monitor: detects red-light violations per approach and lane.
// It fires a camera trigger with per-approach holdoff and keeps saturating
// per-approach counters. It also logs timestamped events through a pending
// stage into an event FIFO.
// Ports:
//   CLK, rst                    clock, asynchronous active-low reset
//   leave_thru/leave_left       exit sensors per approach
//   perm_thru/perm_left         movement permitted per approach
//   clr_cnt                     synchronous clear of counters and overflow
//   cam_trig                    one-cycle camera pulse per approach
//   evt_valid/evt_ready         event FIFO handshake (valid = FIFO not empty;
//                               a pop happens when valid && ready in a cycle)
//   evt_dir/evt_left/evt_ts     head event fields
//   viol_cnt                    packed counters, approach d at [d*CNT_W +: CNT_W]
//   overflow                    sticky: an event was dropped
// Optional feature: define RED_LIGHT_GRACE_EN to enable clearance grace. A
// falling permit edge then opens a GRACE-cycle window in which that movement
// is not flagged.
module red_light_monitor
    import rl_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int CNT_W      = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLDOFF    = 4,
    parameter int GRACE      = 2,
    localparam int DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [NUM_DIR-1:0]       leave_thru,
    input  logic [NUM_DIR-1:0]       leave_left,
    input  logic [NUM_DIR-1:0]       perm_thru,
    input  logic [NUM_DIR-1:0]       perm_left,
    input  logic                     clr_cnt,
    output logic [NUM_DIR-1:0]       cam_trig,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [DIR_W-1:0]         evt_dir,
    output logic                     evt_left,
    output logic [TS_W-1:0]          evt_ts,
    output logic [NUM_DIR*CNT_W-1:0] viol_cnt,
    output logic                     overflow
);

    localparam int NSRC   = 2 * NUM_DIR;
    localparam int SRC_W  = $clog2(NSRC);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [NUM_DIR-1:0] prev_thru_q, prev_left_q;
    logic [NUM_DIR-1:0] trig_q, trig_d;
    logic [HOLD_W-1:0]  hold_q [NUM_DIR];
    logic [HOLD_W-1:0]  hold_d [NUM_DIR];
    logic [CNT_W-1:0]   cnt_q  [NUM_DIR];
    logic [CNT_W-1:0]   cnt_d  [NUM_DIR];
    logic               ovf_q, ovf_d;
    logic [NSRC-1:0]    pend_q, pend_d;
    logic [TS_W-1:0]    pts_q  [NSRC];
    logic [TS_W-1:0]    pts_d  [NSRC];

    logic [NUM_DIR-1:0] ok_thru, ok_left;
    logic [NUM_DIR-1:0] viol_thru, viol_left;
    logic [NSRC-1:0]    viol_src;
    logic [SRC_W-1:0]   push_sel;
    logic               push_any, push;
    logic               fifo_empty, fifo_full;
    rl_evt_t            push_rec, head_rec;

`ifdef RED_LIGHT_GRACE_EN
    localparam int GR_W = (GRACE > 0) ? $clog2(GRACE + 1) : 1;

    logic [NUM_DIR-1:0] perm_thru_q, perm_left_q;
    logic [GR_W-1:0]    gr_thru_q [NUM_DIR];
    logic [GR_W-1:0]    gr_thru_d [NUM_DIR];
    logic [GR_W-1:0]    gr_left_q [NUM_DIR];
    logic [GR_W-1:0]    gr_left_d [NUM_DIR];

    // A permit that falls this cycle already blocks detection, so the window
    // covers the falling cycle plus GRACE cycles after it.
    always_comb begin
        ok_thru = '0;
        ok_left = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            gr_thru_d[d] = (gr_thru_q[d] != '0) ? gr_thru_q[d] - GR_W'(1) : '0;
            gr_left_d[d] = (gr_left_q[d] != '0) ? gr_left_q[d] - GR_W'(1) : '0;
            if (perm_thru_q[d] && !perm_thru[d]) gr_thru_d[d] = GR_W'(GRACE);
            if (perm_left_q[d] && !perm_left[d]) gr_left_d[d] = GR_W'(GRACE);
            ok_thru[d] = (gr_thru_q[d] == '0) && !(perm_thru_q[d] && !perm_thru[d]);
            ok_left[d] = (gr_left_q[d] == '0) && !(perm_left_q[d] && !perm_left[d]);
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            perm_thru_q <= '0;
            perm_left_q <= '0;
            for (int d = 0; d < NUM_DIR; d++) begin
                gr_thru_q[d] <= '0;
                gr_left_q[d] <= '0;
            end
        end else begin
            perm_thru_q <= perm_thru;
            perm_left_q <= perm_left;
            for (int d = 0; d < NUM_DIR; d++) begin
                gr_thru_q[d] <= gr_thru_d[d];
                gr_left_q[d] <= gr_left_d[d];
            end
        end
    end
`else
    assign ok_thru = '1;
    assign ok_left = '1;
`endif

    // Rising exit edge while the movement is not permitted.
    assign viol_thru = leave_thru & ~prev_thru_q & ~perm_thru & ok_thru;
    assign viol_left = leave_left & ~prev_left_q & ~perm_left & ok_left;

    always_comb begin
        viol_src = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            viol_src[src_idx(d, LANE_THRU)] = viol_thru[d];
            viol_src[src_idx(d, LANE_LEFT)] = viol_left[d];
        end
    end

    // Lowest-index pending source wins the single FIFO write slot. Fullness is
    // taken from the start of the cycle, so a pop from a full FIFO frees the
    // slot only for the next cycle.
    always_comb begin
        push_sel = '0;
        push_any = 1'b0;
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (pend_q[s]) begin
                push_any = 1'b1;
                push_sel = SRC_W'(s);
            end
        end
    end

    assign push = push_any && !fifo_full;

    always_comb begin
        push_rec      = '0;
        push_rec.dir  = EVT_DIR_W'(push_sel >> 1);
        push_rec.left = push_sel[0];
        push_rec.ts   = EVT_TS_W'(pts_q[push_sel]);
    end

    always_comb begin
        ts_d   = ts_q + TS_W'(1);
        ovf_d  = ovf_q;
        pend_d = pend_q;
        for (int s = 0; s < NSRC; s++) begin
            pts_d[s] = pts_q[s];
            if (push && (push_sel == SRC_W'(s))) pend_d[s] = 1'b0;
            // A source still holding an unlogged event cannot take another.
            if (viol_src[s]) begin
                if (pend_q[s]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[s] = 1'b1;
                    pts_d[s]  = ts_q;
                end
            end
        end
        if (clr_cnt) ovf_d = 1'b0;

        for (int d = 0; d < NUM_DIR; d++) begin
            logic [1:0] inc;
            inc = {1'b0, viol_thru[d]} + {1'b0, viol_left[d]};
            if (clr_cnt)
                cnt_d[d] = '0;
            else if (cnt_q[d] > CNT_MAX - CNT_W'(inc))
                cnt_d[d] = CNT_MAX;
            else
                cnt_d[d] = cnt_q[d] + CNT_W'(inc);

            trig_d[d] = (viol_thru[d] || viol_left[d]) && (hold_q[d] == '0);
            if (trig_d[d])
                hold_d[d] = HOLD_W'(HOLDOFF);
            else if (hold_q[d] != '0)
                hold_d[d] = hold_q[d] - HOLD_W'(1);
            else
                hold_d[d] = '0;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            ts_q        <= '0;
            prev_thru_q <= '0;
            prev_left_q <= '0;
            trig_q      <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= '0;
            for (int d = 0; d < NUM_DIR; d++) begin
                hold_q[d] <= '0;
                cnt_q[d]  <= '0;
            end
            for (int s = 0; s < NSRC; s++) pts_q[s] <= '0;
        end else begin
            ts_q        <= ts_d;
            prev_thru_q <= leave_thru;
            prev_left_q <= leave_left;
            trig_q      <= trig_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            for (int d = 0; d < NUM_DIR; d++) begin
                hold_q[d] <= hold_d[d];
                cnt_q[d]  <= cnt_d[d];
            end
            for (int s = 0; s < NSRC; s++) pts_q[s] <= pts_d[s];
        end
    end

    rl_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(rl_evt_t))
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (rst),
        .push_i  (push),
        .din_i   (push_rec),
        .pop_i   (evt_ready),
        .dout_o  (head_rec),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign cam_trig  = trig_q;
    assign overflow  = ovf_q;
    assign evt_valid = !fifo_empty;
    assign evt_dir   = head_rec.dir[DIR_W-1:0];
    assign evt_left  = head_rec.left;
    assign evt_ts    = head_rec.ts[TS_W-1:0];

    always_comb begin
        viol_cnt = '0;
        for (int d = 0; d < NUM_DIR; d++) viol_cnt[d*CNT_W +: CNT_W] = cnt_q[d];
    end

endmodule

// File: tb/tb_red_light_monitor.sv
module tb_red_light_monitor;

  localparam int NUM_DIR = 4;
  localparam int CNT_W   = 8;
  localparam int TS_W    = 16;
  localparam int HOLDOFF = 4;
  localparam int EW      = 2 + 1 + TS_W;

  logic                     CLK;
  logic                     rst;
  logic [NUM_DIR-1:0]       leave_thru, leave_left, perm_thru, perm_left;
  logic                     clr_cnt;
  logic [NUM_DIR-1:0]       cam_trig;
  logic                     evt_valid, evt_ready;
  logic [1:0]               evt_dir;
  logic                     evt_left;
  logic [TS_W-1:0]          evt_ts;
  logic [NUM_DIR*CNT_W-1:0] viol_cnt;
  logic                     overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cyc;
  int last_trig [NUM_DIR];
  logic [EW-1:0] exp_q [$];

  red_light_monitor #(
    .NUM_DIR(NUM_DIR), .CNT_W(CNT_W), .TS_W(TS_W),
    .FIFO_DEPTH(8), .HOLDOFF(HOLDOFF), .GRACE(2)
  ) dut (
    .CLK(CLK), .rst(rst),
    .leave_thru(leave_thru), .leave_left(leave_left),
    .perm_thru(perm_thru), .perm_left(perm_left),
    .clr_cnt(clr_cnt), .cam_trig(cam_trig),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_dir(evt_dir), .evt_left(evt_left), .evt_ts(evt_ts),
    .viol_cnt(viol_cnt), .overflow(overflow)
  );

  // clock / reset-relative cycle model (equals the timestamp the design should hold)
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge rst) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int d);
    return viol_cnt[d*CNT_W +: CNT_W];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic reset_model();
    for (int d = 0; d < NUM_DIR; d++) last_trig[d] = -1000;
    exp_q.delete();
  endtask

  // One rising exit edge on approach d (lanes th/lf), sensor dropped after one cycle.
  task automatic pulse(input int d, input bit th, input bit lf, input bit chk);
    bit trg;
    trg = (int'(cyc) - last_trig[d]) > HOLDOFF;
    if (trg) last_trig[d] = int'(cyc);
    if (chk && th) exp_q.push_back({d[1:0], 1'b0, cyc[TS_W-1:0]});
    if (chk && lf) exp_q.push_back({d[1:0], 1'b1, cyc[TS_W-1:0]});
    leave_thru[d] = th;
    leave_left[d] = lf;
    tick(1);
    if (chk) check("cam_trig_pulse", 64'(cam_trig), trg ? 64'(1 << d) : 64'd0);
    leave_thru[d] = 1'b0;
    leave_left[d] = 1'b0;
    tick(1);
    if (chk) check("cam_trig_clear", 64'(cam_trig), 64'd0);
  endtask

  task automatic drain();
    logic [EW-1:0] exp;
    while (exp_q.size() > 0) begin
      int t = 0;
      while (!evt_valid && t < 20) begin
        tick(1);
        t++;
      end
      check("evt_valid_head", 64'(evt_valid), 64'd1);
      exp = exp_q.pop_front();
      check("evt_head", 64'({evt_dir, evt_left, evt_ts}), 64'(exp));
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
    end
    tick(1);
    check("evt_drained", 64'(evt_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    leave_thru = '0; leave_left = '0; perm_thru = '0; perm_left = '0;
    clr_cnt = 1'b0; evt_ready = 1'b0;
    reset_model();
    tick(3);
    check("rst_cam_trig", 64'(cam_trig), 64'd0);
    check("rst_evt_valid", 64'(evt_valid), 64'd0);
    check("rst_viol_cnt", 64'(viol_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_evt_fields", 64'({evt_dir, evt_left, evt_ts}), 64'd0);
    rst = 1'b1;
    tick(2);

    // held-high through sensor on approach 2 counts and triggers once
    exp_q.push_back({2'd2, 1'b0, cyc[TS_W-1:0]});
    last_trig[2] = int'(cyc);
    leave_thru[2] = 1'b1;
    tick(1);
    check("hold_trig_on", 64'(cam_trig), 64'h4);
    tick(1);
    check("hold_trig_off", 64'(cam_trig), 64'd0);
    tick(8);
    check("hold_cnt2", 64'(cnt_of(2)), 64'd1);
    check("hold_evt_valid", 64'(evt_valid), 64'd1);
    leave_thru[2] = 1'b0;
    tick(1);
    drain();

    // permitted movement: nothing happens
    perm_thru[1] = 1'b1;
    pulse(1, 1'b1, 1'b0, 1'b0);
    check("perm_no_trig", 64'(cam_trig), 64'd0);
    check("perm_no_cnt", 64'(cnt_of(1)), 64'd0);
    check("perm_no_evt", 64'(evt_valid), 64'd0);
    perm_thru[1] = 1'b0;
    tick(6);

    // holdoff on approach 0: detections at c, c+3 (suppressed), c+5 (triggers)
    pulse(0, 1'b1, 1'b0, 1'b1);
    tick(1);
    pulse(0, 1'b1, 1'b0, 1'b1);
    pulse(0, 1'b1, 1'b0, 1'b1);
    check("holdoff_cnt0", 64'(cnt_of(0)), 64'd3);
    drain();

    // synchronous clear
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("clr_cnt_all", 64'(viol_cnt), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    tick(6);

    // FIFO full, pending, overflow, ordered release
    for (int s = 0; s < 8; s++) pulse(s / 2, bit'(s % 2 == 0), bit'(s % 2 == 1), 1'b1);
    check("full_valid", 64'(evt_valid), 64'd1);
    check("full_no_ovf", 64'(overflow), 64'd0);
    pulse(0, 1'b1, 1'b0, 1'b1);
    check("pending_no_ovf", 64'(overflow), 64'd0);
    pulse(0, 1'b1, 1'b0, 1'b0);
    check("repeat_ovf", 64'(overflow), 64'd1);
    check("ovf_cnt0", 64'(cnt_of(0)), 64'd4);
    check("ovf_cnt3", 64'(cnt_of(3)), 64'd2);
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);
    tick(6);

    // saturation on approach 3
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 126; i++) pulse(3, 1'b1, 1'b1, 1'b0);
    check("sat_252", 64'(cnt_of(3)), 64'd252);
    pulse(3, 1'b1, 1'b0, 1'b0);
    check("sat_253", 64'(cnt_of(3)), 64'd253);
    pulse(3, 1'b1, 1'b1, 1'b0);
    check("sat_255_exact", 64'(cnt_of(3)), 64'd255);
    pulse(3, 1'b1, 1'b1, 1'b0);
    check("sat_255_dual", 64'(cnt_of(3)), 64'd255);
    pulse(3, 1'b1, 1'b0, 1'b0);
    check("sat_255_single", 64'(cnt_of(3)), 64'd255);
    tick(6);
    evt_ready = 1'b0;
    check("sat_fifo_empty", 64'(evt_valid), 64'd0);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("sat_clr_cnt3", 64'(cnt_of(3)), 64'd0);
    check("sat_clr_ovf", 64'(overflow), 64'd0);
    tick(6);

    // clear in the same cycle as a violation: logged, not counted
    exp_q.push_back({2'd3, 1'b1, cyc[TS_W-1:0]});
    clr_cnt = 1'b1;
    leave_left[3] = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    leave_left[3] = 1'b0;
    tick(1);
    check("clr_viol_cnt3", 64'(cnt_of(3)), 64'd0);
    drain();

    // reset mid-operation discards queued and pending events
    pulse(1, 1'b1, 1'b0, 1'b0);
    pulse(2, 1'b0, 1'b1, 1'b0);
    check("pre_rst_valid", 64'(evt_valid), 64'd1);
    rst = 1'b0;
    #2;
    check("mid_rst_valid", 64'(evt_valid), 64'd0);
    check("mid_rst_cnt", 64'(viol_cnt), 64'd0);
    check("mid_rst_ts", 64'(evt_ts), 64'd0);
    tick(1);
    rst = 1'b1;
    reset_model();
    tick(3);
    check("post_rst_valid", 64'(evt_valid), 64'd0);
    check("post_rst_ovf", 64'(overflow), 64'd0);

`ifdef RED_LIGHT_GRACE_EN
    // grace window after perm_left[0] falls
    perm_left[0] = 1'b1;
    tick(2);
    perm_left[0] = 1'b0;
    tick(1);
    leave_left[0] = 1'b1;
    tick(1);
    check("grace_no_trig", 64'(cam_trig), 64'd0);
    leave_left[0] = 1'b0;
    tick(1);
    check("grace_no_cnt", 64'(cnt_of(0)), 64'd0);
    check("grace_no_evt", 64'(evt_valid), 64'd0);
    perm_left[0] = 1'b1;
    tick(2);
    perm_left[0] = 1'b0;
    tick(3);
    pulse(0, 1'b0, 1'b1, 1'b1);
    check("grace_after_cnt", 64'(cnt_of(0)), 64'd1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
